// File: rtl/serial_clk_shifter.sv
// Serial transmit stage: MSB-first shifter with a free-running sclk while
// start is high, back-to-back framing and clean stop or mid-frame abort.
module serial_clk_shifter #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             sclk,
    output logic             sdo,
    output logic             busy,
    output logic             load,
    output logic             done,
    output logic             aborted,
    output logic [7:0]       frames
);

    localparam int HW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [HW-1:0] HMAX = HW'(DIV - 1);
    localparam logic [BW-1:0] BMAX = BW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [HW-1:0]    hcnt_q;
    logic [BW-1:0]    bitcnt_q;
    logic             sclk_q;
    logic             sdo_q;
    logic             busy_q;
    logic             load_q;
    logic             done_q;
    logic             aborted_q;
    logic [7:0]       frames_q;

    logic half_end;
    logic last_fall;

    assign half_end  = (hcnt_q == HMAX);
    // The last falling edge always completes the frame, even with start low.
    assign last_fall = half_end && sclk_q && (bitcnt_q == BMAX);

    assign sclk    = sclk_q;
    assign sdo     = sdo_q;
    assign busy    = busy_q;
    assign load    = load_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign frames  = frames_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            hcnt_q    <= '0;
            bitcnt_q  <= '0;
            sclk_q    <= 1'b0;
            sdo_q     <= 1'b0;
            busy_q    <= 1'b0;
            load_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            frames_q  <= '0;
        end else begin
            load_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    sclk_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        shreg_q  <= din;
                        sdo_q    <= din[WIDTH-1];
                        hcnt_q   <= '0;
                        bitcnt_q <= '0;
                        busy_q   <= 1'b1;
                        load_q   <= 1'b1;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!start && !last_fall) begin
                        state_q   <= IDLE;
                        sclk_q    <= 1'b0;
                        sdo_q     <= 1'b0;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                        hcnt_q    <= '0;
                        bitcnt_q  <= '0;
                    end else if (!half_end) begin
                        hcnt_q <= hcnt_q + HW'(1);
                    end else begin
                        hcnt_q <= '0;
                        sclk_q <= ~sclk_q;
                        if (sclk_q) begin
                            if (bitcnt_q != BMAX) begin
                                bitcnt_q <= bitcnt_q + BW'(1);
                                shreg_q  <= shreg_q << 1;
                                sdo_q    <= shreg_q[WIDTH-2];
                            end else begin
                                done_q   <= 1'b1;
                                frames_q <= frames_q + 8'd1;
                                bitcnt_q <= '0;
                                if (start) begin
                                    shreg_q <= din;
                                    sdo_q   <= din[WIDTH-1];
                                    load_q  <= 1'b1;
                                end else begin
                                    state_q <= IDLE;
                                    busy_q  <= 1'b0;
                                    sdo_q   <= 1'b0;
                                end
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_clk_shifter.sv
// Bench for serial_clk_shifter: DIV=1 and DIV=3 instances on shared stimulus,
// a time-since-load model checked every cycle, plus directed literal checks.
module tb_serial_clk_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic       start;
    logic [3:0] din;

    logic [1:0] sclk_w, sdo_w, busy_w, load_w, done_w, ab_w;
    logic [7:0] fr_w [2];

    int checks = 0;
    int errors = 0;

    serial_clk_shifter #(.WIDTH(4), .DIV(1)) u0 (
        .clk(clk), .rstn(rstn), .start(start), .din(din),
        .sclk(sclk_w[0]), .sdo(sdo_w[0]), .busy(busy_w[0]),
        .load(load_w[0]), .done(done_w[0]), .aborted(ab_w[0]),
        .frames(fr_w[0])
    );

    serial_clk_shifter #(.WIDTH(4), .DIV(3)) u1 (
        .clk(clk), .rstn(rstn), .start(start), .din(din),
        .sclk(sclk_w[1]), .sdo(sdo_w[1]), .busy(busy_w[1]),
        .load(load_w[1]), .done(done_w[1]), .aborted(ab_w[1]),
        .frames(fr_w[1])
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [13:0] dut_out(input int i);
        return {sclk_w[i], sdo_w[i], busy_w[i], load_w[i],
                done_w[i], ab_w[i], fr_w[i]};
    endfunction

    // Model: a frame is 8*DIV edges after its load; outputs follow from the
    // elapsed edge count t alone.
    bit         m_valid [2];
    bit         m_busy  [2];
    int         m_t     [2];
    logic [3:0] m_word  [2];
    logic [7:0] m_fr    [2];
    logic [13:0] e_out  [2];

    task automatic model_step(input int i, input int div);
        logic s, so, l, d, a;
        int n;
        n = 8 * div;
        s = 0; so = 0; l = 0; d = 0; a = 0;
        if (!rstn) begin
            m_busy[i] = 0;
            m_t[i]    = 0;
            m_fr[i]   = 0;
        end else if (!m_busy[i]) begin
            if (start) begin
                m_busy[i] = 1;
                m_word[i] = din;
                m_t[i]    = 0;
                l         = 1;
                so        = din[3];
            end
        end else begin
            m_t[i] = m_t[i] + 1;
            if (m_t[i] == n) begin
                d       = 1;
                m_fr[i] = m_fr[i] + 8'd1;
                if (start) begin
                    m_word[i] = din;
                    m_t[i]    = 0;
                    l         = 1;
                    so        = din[3];
                end else begin
                    m_busy[i] = 0;
                end
            end else if (!start) begin
                a         = 1;
                m_busy[i] = 0;
            end else begin
                s  = ((m_t[i] / div) % 2) == 1;
                so = m_word[i][3 - m_t[i] / (2 * div)];
            end
        end
        e_out[i]   = {s, so, m_busy[i], l, d, a, m_fr[i]};
        m_valid[i] = 1;
    endtask

    always @(posedge clk) begin
        model_step(0, 1);
        model_step(1, 3);
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++)
            if (m_valid[i])
                chk($sformatf("cycle_dut%0d", i), dut_out(i), e_out[i]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        prev_s, prev_d;
        logic [7:0]  bits;
        logic [16:0] ldm, dnm;
        int          tog, chg, bad, ndone;

        rstn = 0; start = 0; din = '0;
        tick(); tick();
        chk("reset_dut0", dut_out(0), 14'h0);
        chk("reset_dut1", dut_out(1), 14'h0);
        rstn = 1;
        tick();

        // single frame, din=1011
        din = 4'b1011; start = 1;
        tick();
        chk("sf_e0_busy_load_sdo", {busy_w[0], load_w[0], sdo_w[0]}, 3'b111);
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk($sformatf("sf_sclk_e%0d", e), sclk_w[0], (e % 2));
            if (e == 2) chk("sf_sdo_e2", sdo_w[0], 1'b0);
            if (e == 4) chk("sf_sdo_e4", sdo_w[0], 1'b1);
            if (e == 6) chk("sf_sdo_e6", sdo_w[0], 1'b1);
        end
        start = 0;
        tick();
        chk("sf_e8_done_busy_ab_sclk",
            {done_w[0], busy_w[0], ab_w[0], sclk_w[0]}, 4'b1000);
        chk("sf_e8_frames", fr_w[0], 8'd1);
        tick();

        // back-to-back A then 5
        din = 4'hA; start = 1;
        tick();
        chk("b2b_e0_load", load_w[0], 1'b1);
        din = 4'h5;
        prev_s = sclk_w[0]; bits = '0; tog = 0; ldm = '0; dnm = '0;
        for (int e = 1; e <= 16; e++) begin
            if (e == 16) start = 0;
            tick();
            if (sclk_w[0] !== prev_s) tog++;
            prev_s = sclk_w[0];
            if (sclk_w[0]) bits = {bits[6:0], sdo_w[0]};
            ldm[e] = load_w[0];
            dnm[e] = done_w[0];
        end
        chk("b2b_toggles", tog, 16);
        chk("b2b_bits", bits, 8'hA5);
        chk("b2b_load_mask", ldm, 17'h00100);
        chk("b2b_done_mask", dnm, 17'h10100);
        chk("b2b_frames", fr_w[0], 8'd3);
        tick();

        // abort at E5, restart at E7
        din = 4'h9; start = 1;
        tick();
        for (int e = 1; e <= 4; e++) tick();
        start = 0;
        tick();
        chk("ab_e5_ab_sclk_busy_done",
            {ab_w[0], sclk_w[0], busy_w[0], done_w[0]}, 4'b1000);
        chk("ab_e5_frames", fr_w[0], 8'd3);
        tick();
        start = 1;
        tick();
        chk("ab_e7_load_busy_sdo", {load_w[0], busy_w[0], sdo_w[0]}, 3'b111);
        start = 0;
        tick();
        chk("ab_e8_aborted", ab_w[0], 1'b1);
        tick();

        // reset during bit 2
        din = 4'hF; start = 1;
        tick();
        for (int e = 1; e <= 4; e++) tick();
        rstn = 0;
        tick();
        chk("mid_reset_dut0", dut_out(0), 14'h0);
        chk("mid_reset_dut1", dut_out(1), 14'h0);
        start = 0; rstn = 1;
        tick();

        // DIV=3 frame on u1
        din = 4'b0110; start = 1;
        tick();
        chk("d3_e0_load_sdo", {load_w[1], sdo_w[1]}, 2'b10);
        prev_s = sclk_w[1]; prev_d = sdo_w[1]; chg = 0; bad = 0;
        for (int e = 1; e <= 24; e++) begin
            if (e == 24) start = 0;
            tick();
            if (sdo_w[1] !== prev_d) begin
                chg++;
                if (!(prev_s === 1'b1 && sclk_w[1] === 1'b0)) bad++;
            end
            prev_s = sclk_w[1]; prev_d = sdo_w[1];
            if (e == 2) chk("d3_sclk_e2", sclk_w[1], 1'b0);
            if (e == 3) chk("d3_sclk_e3", sclk_w[1], 1'b1);
            if (e == 6) chk("d3_sclk_e6", sclk_w[1], 1'b0);
            if (e == 23) chk("d3_done_e23", done_w[1], 1'b0);
        end
        chk("d3_e24_done_busy", {done_w[1], busy_w[1]}, 2'b10);
        chk("d3_e24_frames", fr_w[1], 8'd1);
        chk("d3_sdo_changes", chg, 2);
        chk("d3_sdo_off_fall", bad, 0);
        chk("d3_dut0_frames", fr_w[0], 8'd3);
        tick();

        // 256 frames wrap the counter
        rstn = 0;
        tick();
        rstn = 1;
        tick();
        din = 4'h3; start = 1; ndone = 0;
        for (int e = 0; e <= 2048; e++) begin
            if (e == 2048) start = 0;
            tick();
            if (done_w[0]) ndone++;
            if (e == 2047) chk("wrap_frames_255", fr_w[0], 8'd255);
        end
        chk("wrap_frames_0", fr_w[0], 8'd0);
        chk("wrap_last_done", done_w[0], 1'b1);
        chk("wrap_done_count", ndone, 256);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_clk_shifter.md
Name: serial_clk_shifter

Overview:
- Serial transmit stage that drives the `sclk`/`start` pair our SVA benches check: while `start` is held high, `sclk` toggles continuously.
- Shifts a parallel word out MSB-first on `sdo`, with data changing on the falling edge of `sclk`.
- Frames run back-to-back while `start` stays high. Dropping `start` ends the transfer cleanly at a frame boundary, or aborts it mid-frame.
- Sits directly upstream of the serial consumer and the assertion checker.

Parameters:
- WIDTH, 4, bits per frame (>=2).
- DIV, 1, clk cycles per `sclk` half-period (>=1).

Ports:
- clk, input, 1, system clock; all logic on posedge.
- rstn, input, 1, synchronous active-low reset.
- start, input, 1, level request; transfer runs while high.
- din, input, WIDTH, parallel word; sampled when `load` is asserted.
- sclk, output, 1, serial clock; idle low.
- sdo, output, 1, serial data, MSB first.
- busy, output, 1, high while in SHIFT.
- load, output, 1, 1-cycle pulse: `din` captured this edge.
- done, output, 1, 1-cycle pulse: frame completed.
- aborted, output, 1, 1-cycle pulse: frame cut mid-way.
- frames, output, 8, completed-frame count; wraps 255->0.

Behaviour:
- Reset (`rstn`=0 sampled at posedge):
  - state=IDLE; sclk=0, sdo=0, busy=0, load=0, done=0, aborted=0, frames=0.
  - Internal counters and shift register cleared.
  - Applies from any state, mid-frame included; no done/aborted pulse is produced.
- Internal state: shift register `shreg[WIDTH-1:0]`, half-period counter `hcnt` (0..DIV-1), bit counter `bitcnt` (0..WIDTH-1).
- IDLE:
  - sclk=0, busy=0.
  - If start=1 sampled: shreg<=din, sdo<=din[WIDTH-1], hcnt<=0, bitcnt<=0, busy<=1, load<=1, go to SHIFT.
  - Latency: start sampled -> sdo valid and busy at the same edge; first sclk rise is DIV edges later.
- SHIFT, each edge, in priority order:
  1. start=0, not a last-bit falling edge (abort case):
     - Go to IDLE; sclk<=0, sdo<=0, busy<=0, aborted<=1.
     - frames is unchanged.
  2. hcnt!=DIV-1: hcnt<=hcnt+1; no other change.
  3. hcnt==DIV-1: hcnt<=0, sclk<=~sclk.
     - Rising edge (sclk was 0): nothing else changes; the receiver samples sdo here.
     - Falling edge, bitcnt<WIDTH-1: bitcnt++, shreg<=shreg<<1, sdo<=shreg[WIDTH-2].
     - Falling edge, bitcnt==WIDTH-1: done<=1, frames<=frames+1, bitcnt<=0. Then:
       - If start=1 (back-to-back): shreg<=din, sdo<=din[WIDTH-1], load<=1; stay in SHIFT. sclk has no gap and no extra low phase.
       - If start=0 (clean stop): go to IDLE, busy<=0, sdo<=0, aborted=0.
- Frame length is 2*WIDTH*DIV clk cycles. With DIV=1, sclk changes on every clk edge while busy, which satisfies `start throughout $changed(sclk)` at clk edges.
- A start glitch low while in IDLE is ignored. Re-asserting start the edge after an abort begins a new frame, with a fresh load of din.
- done and aborted are never high in the same cycle. load and done coincide only on a back-to-back reload.

Test Plan:
- Reset mid-frame: rstn=0 during bit 2 -> next edge sclk=0, sdo=0, busy=0, frames=0; no done or aborted pulse.
- Single frame, WIDTH=4, DIV=1, din=4'b1011:
  - Stimulus: start sampled high at E0..E7, low at E8.
  - Response: E0 busy=1, load=1, sdo=1. sclk=1 at E1, E3, E5, E7; sclk=0 at E2, E4, E6, E8.
  - sdo: 0 at E2, 1 at E4, 1 at E6.
  - E8: done=1, busy=0, frames=1, aborted=0.
- Back-to-back, din=4'hA then 4'h5, start held 16 cycles:
  - load pulses at E0 and E8; done at E8 and E16.
  - sclk toggles every edge E1..E16 with no gap; serial bits 1010 then 0101; frames=2.
- Abort: start low at E5 of a frame -> E5 aborted=1, sclk=0, busy=0, frames unchanged; then start high at E7 -> load=1, new frame.
- DIV=3, WIDTH=4: sclk half-period is 3 clk cycles; done at E24 after start at E0; sdo changes only on sclk falling edges.
- Wrap: run 256 frames -> frames reads 0 after the 256th done pulse.
